// File: rtl/fft_bin_capture_if.sv
// Stream-in / result-out bundle between the FFT, fft_bin_capture and the impedance logic.
// Signal names keep the block's i_/o_ port naming as seen from the capture block.
interface fft_bin_capture_if #(
    parameter int unsigned DW     = 15,
    parameter int unsigned LGSIZE = 8
);
    logic                i_ce;
    logic                i_sync;
    logic [2*DW-1:0]     i_result;
    logic [LGSIZE-1:0]   i_bin;
    logic                o_valid;
    logic                i_ready;
    logic [DW-1:0]       o_re;
    logic [DW-1:0]       o_im;
    logic [LGSIZE-1:0]   o_pk_bin;
    logic [2*DW:0]       o_pk_mag;
    logic                o_drop;
    logic                o_resync;

    modport master (
        output i_ce, i_sync, i_result, i_bin, i_ready,
        input  o_valid, o_re, o_im, o_pk_bin, o_pk_mag, o_drop, o_resync
    );

    modport slave (
        input  i_ce, i_sync, i_result, i_bin, i_ready,
        output o_valid, o_re, o_im, o_pk_bin, o_pk_mag, o_drop, o_resync
    );
endinterface

// File: rtl/fft_bin_capture.sv
// Per-frame FFT bin tracker: captures one selected bin, finds the peak-magnitude bin,
// and presents one result per frame on a valid/ready interface.
module fft_bin_capture #(
    parameter int unsigned DW     = 15,
    parameter int unsigned LGSIZE = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    fft_bin_capture_if.slave  bus
);
    localparam int unsigned SW = 2*DW;
    localparam int unsigned MW = 2*DW+1;
    localparam logic [LGSIZE-1:0] LAST_BIN = '1;

    typedef enum logic {IDLE = 1'b0, ACQ = 1'b1} state_t;

    state_t                 state;
    logic [LGSIZE-1:0]      cnt;
    logic [LGSIZE-1:0]      sel;
    logic signed [DW-1:0]   cap_re, cap_im;
    logic signed [DW-1:0]   done_re, done_im;

    logic                   start_c, take_c, last_c, hit_c;
    logic [LGSIZE-1:0]      bin_c, sel_c;
    logic signed [DW-1:0]   re_c, im_c;
    logic signed [SW-1:0]   re_w_c, im_w_c;

    // Sample classification: which bin this i_ce sample is, and whether it is captured/last
    always_comb begin
        re_c    = bus.i_result[SW-1:DW];
        im_c    = bus.i_result[DW-1:0];
        re_w_c  = SW'(re_c);
        im_w_c  = SW'(im_c);
        start_c = bus.i_ce && bus.i_sync;
        take_c  = bus.i_ce && (bus.i_sync || (state == ACQ));
        bin_c   = start_c ? '0 : cnt;
        sel_c   = start_c ? bus.i_bin : sel;
        hit_c   = take_c && (bin_c == sel_c);
        last_c  = take_c && !bus.i_sync && (cnt == LAST_BIN);
    end

    // Frame FSM, bin counter and selected-bin capture
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sel          <= '0;
            cap_re       <= '0;
            cap_im       <= '0;
            done_re      <= '0;
            done_im      <= '0;
            bus.o_resync <= 1'b0;
        end else begin
            bus.o_resync <= 1'b0;
            if (start_c) begin
                bus.o_resync <= (state == ACQ) && (cnt != '0);
                state        <= ACQ;
                cnt          <= LGSIZE'(1);
                sel          <= bus.i_bin;
            end else if (take_c) begin
                if (last_c) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + LGSIZE'(1);
                end
            end
            if (hit_c) begin
                cap_re <= re_c;
                cap_im <= im_c;
            end
            // Snapshot the capture at frame end so the next frame can overwrite cap_* freely
            if (last_c) begin
                done_re <= hit_c ? re_c : cap_re;
                done_im <= hit_c ? im_c : cap_im;
            end
        end
    end

    logic                s1_v, s1_first, s1_last;
    logic [LGSIZE-1:0]   s1_bin;
    logic [SW-1:0]       s1_re2, s1_im2;
    logic                s2_v, s2_first, s2_last;
    logic [LGSIZE-1:0]   s2_bin;
    logic [MW-1:0]       s2_mag;
    logic [LGSIZE-1:0]   pk_bin;
    logic [MW-1:0]       pk_mag;
    logic                fin;

    // Magnitude pipeline (free-running) followed by the peak compare/update stage
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_bin   <= '0;
            s1_re2   <= '0;
            s1_im2   <= '0;
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_bin   <= '0;
            s2_mag   <= '0;
            pk_bin   <= '0;
            pk_mag   <= '0;
            fin      <= 1'b0;
        end else begin
            s1_v     <= take_c;
            s1_first <= start_c;
            s1_last  <= last_c;
            s1_bin   <= bin_c;
            s1_re2   <= $unsigned(re_w_c * re_w_c);
            s1_im2   <= $unsigned(im_w_c * im_w_c);

            s2_v     <= s1_v;
            s2_first <= s1_v && s1_first;
            s2_last  <= s1_v && s1_last;
            s2_bin   <= s1_bin;
            s2_mag   <= MW'(s1_re2) + MW'(s1_im2);

            // Strict compare keeps the lowest index on ties; bin 0 always reseeds
            if (s2_v && (s2_first || (s2_mag > pk_mag))) begin
                pk_bin <= s2_bin;
                pk_mag <= s2_mag;
            end
            fin <= s2_v && s2_last;
        end
    end

    // Result register with valid/ready handshake and drop-on-backpressure
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_valid  <= 1'b0;
            bus.o_re     <= '0;
            bus.o_im     <= '0;
            bus.o_pk_bin <= '0;
            bus.o_pk_mag <= '0;
            bus.o_drop   <= 1'b0;
        end else begin
            bus.o_drop <= 1'b0;
            if (fin) begin
                if (!bus.o_valid || bus.i_ready) begin
                    bus.o_valid  <= 1'b1;
                    bus.o_re     <= done_re;
                    bus.o_im     <= done_im;
                    bus.o_pk_bin <= pk_bin;
                    bus.o_pk_mag <= pk_mag;
                end else begin
                    bus.o_drop <= 1'b1;
                end
            end else if (bus.o_valid && bus.i_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_bin_capture.sv
// Directed bench for fft_bin_capture: frame-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_fft_bin_capture;
    localparam int unsigned DW = 15;
    localparam int unsigned LG = 8;
    localparam int NB = 256;

    logic i_clk;
    logic rst_n;

    fft_bin_capture_if #(.DW(DW), .LGSIZE(LG)) bus ();

    fft_bin_capture #(.DW(DW), .LGSIZE(LG)) dut (
        .i_clk     (i_clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: expected output register contents after each posedge
    logic          ev, ed, er;
    logic [DW-1:0] e_re, e_im;
    logic [LG-1:0] e_bin;
    logic [2*DW:0] e_mag;
    int     cyc;
    bit     in_frame;
    int     fn, fsel;
    int     fre [NB];
    int     fim [NB];
    int     q_due [$];
    int     q_re  [$];
    int     q_im  [$];
    int     q_bin [$];
    longint q_mag [$];

    int n_rise, n_drop, n_resync;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void pat(input int kind, input int k, output int re, output int im);
        case (kind)
            0:       begin re = k; im = -k; end
            1:       begin re = 0; im = 0; end
            default: begin re = (k == 77) ? -16384 : 1; im = re; end
        endcase
    endfunction

    task automatic smp(input bit ce, input bit sync, input int re, input int im);
        bus.i_ce     = ce;
        bus.i_sync   = sync;
        bus.i_result = {DW'(re), DW'(im)};
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) smp(1'b0, 1'b0, 0, 0);
    endtask

    // Frame of nb bins starting with sync; gaps inserts a ce=0 (sync=1, junk data) clock after each bin
    task automatic frame(input int kind, input int sel, input int nb, input bit gaps);
        int re, im;
        bus.i_bin = LG'(sel);
        for (int k = 0; k < nb; k++) begin
            pat(kind, k, re, im);
            smp(1'b1, k == 0, re, im);
            if (gaps) smp(1'b0, 1'b1, $urandom_range(0, 255), 3);
        end
        bus.i_ce = 1'b0;
    endtask

    task automatic consume();
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        bus.i_ready = 1'b0;
        chk("consumed_valid_low", longint'(bus.o_valid), 0);
    endtask

    task automatic chk_result(input string t, input int re, input int im, input int bin, input longint mag);
        chk({t, "_valid"}, longint'(bus.o_valid), 1);
        chk({t, "_re"}, longint'($signed(bus.o_re)), re);
        chk({t, "_im"}, longint'($signed(bus.o_im)), im);
        chk({t, "_pk_bin"}, longint'(bus.o_pk_bin), bin);
        chk({t, "_pk_mag"}, longint'(bus.o_pk_mag), mag);
    endtask

    task automatic model_step();
        int re, im, best;
        longint m, bm;
        cyc++;
        ed = 1'b0;
        er = 1'b0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            if (!ev || bus.i_ready) begin
                ev = 1'b1;
                e_re = DW'(q_re[0]);
                e_im = DW'(q_im[0]);
                e_bin = LG'(q_bin[0]);
                e_mag = (2*DW+1)'(q_mag[0]);
            end else begin
                ed = 1'b1;
            end
            void'(q_due.pop_front()); void'(q_re.pop_front()); void'(q_im.pop_front());
            void'(q_bin.pop_front()); void'(q_mag.pop_front());
        end else if (ev && bus.i_ready) begin
            ev = 1'b0;
        end
        if (bus.i_ce) begin
            if (bus.i_sync) begin
                if (in_frame) er = 1'b1;
                in_frame = 1'b1;
                fn = 0;
                fsel = int'(bus.i_bin);
            end
            if (in_frame) begin
                fre[fn] = int'($signed(bus.i_result[2*DW-1:DW]));
                fim[fn] = int'($signed(bus.i_result[DW-1:0]));
                fn++;
                if (fn == NB) begin
                    in_frame = 1'b0;
                    best = 0;
                    bm = -1;
                    for (int k = 0; k < NB; k++) begin
                        re = fre[k]; im = fim[k];
                        m = longint'(re) * re + longint'(im) * im;
                        if (m > bm) begin bm = m; best = k; end
                    end
                    q_due.push_back(cyc + 3);
                    q_re.push_back(fre[fsel]);
                    q_im.push_back(fim[fsel]);
                    q_bin.push_back(best);
                    q_mag.push_back(bm);
                end
            end
        end
    endtask

    task automatic model_reset();
        ev = 0; ed = 0; er = 0;
        e_re = '0; e_im = '0; e_bin = '0; e_mag = '0;
        cyc = 0; in_frame = 0; fn = 0; fsel = 0;
        q_due.delete(); q_re.delete(); q_im.delete(); q_bin.delete(); q_mag.delete();
    endtask

    task automatic compare_cycle();
        bit ok;
        ok = (bus.o_valid === ev) && (bus.o_drop === ed) && (bus.o_resync === er) &&
             (!ev || ((bus.o_re === e_re) && (bus.o_im === e_im) &&
                      (bus.o_pk_bin === e_bin) && (bus.o_pk_mag === e_mag)));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cycle_%0d: got v=%b d=%b rs=%b re=%0d im=%0d bin=%0d mag=%0d required v=%b d=%b rs=%b re=%0d im=%0d bin=%0d mag=%0d",
                     cyc, bus.o_valid, bus.o_drop, bus.o_resync, $signed(bus.o_re), $signed(bus.o_im),
                     bus.o_pk_bin, bus.o_pk_mag, ev, ed, er, $signed(e_re), $signed(e_im), e_bin, e_mag);
        end
    endtask

    initial begin
        int v0, d0, r0;
        bit pv;
        rst_n = 1'b1;
        bus.i_ce = 1'b0; bus.i_sync = 1'b0; bus.i_result = '0; bus.i_bin = '0; bus.i_ready = 1'b0;
        n_rise = 0; n_drop = 0; n_resync = 0;
        model_reset();
        fork
            forever begin
                @(posedge i_clk or negedge rst_n);
                if (!rst_n) model_reset();
                else model_step();
            end
            forever begin
                @(negedge i_clk);
                if (bus.o_valid && !pv) n_rise++;
                if (bus.o_drop) n_drop++;
                if (bus.o_resync) n_resync++;
                pv = bus.o_valid;
                if (rst_n) compare_cycle();
            end
        join_none

        #1 rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", longint'({bus.o_valid, bus.o_re, bus.o_im, bus.o_pk_bin, bus.o_pk_mag,
                                        bus.o_drop, bus.o_resync}), 0);
        rst_n = 1'b1;
        idle(2);

        // Single frame: bin k = {k,-k}, select bin 5; result appears exactly 3 clocks after bin 255
        frame(0, 5, NB, 0);
        idle(2);
        chk("latency_not_early", longint'(bus.o_valid), 0);
        idle(1);
        chk_result("single", 5, -5, 255, 130050);
        idle(3);
        chk("single_held", longint'(bus.o_pk_mag), 130050);
        consume();

        // All-zero frame with bin 0 selected: tie keeps bin 0
        frame(1, 0, NB, 0);
        idle(3);
        chk_result("zeros", 0, 0, 0, 0);
        consume();

        // Extreme negative values at bin 77
        frame(2, 77, NB, 0);
        idle(3);
        chk_result("extreme", -16384, -16384, 77, 64'd536870912);
        consume();

        // Backpressure over two back-to-back frames: second is dropped, first held
        d0 = n_drop;
        frame(0, 5, NB, 0);
        frame(1, 3, NB, 0);
        idle(4);
        chk("bp_drop_count", n_drop - d0, 1);
        chk_result("bp_held", 5, -5, 255, 130050);
        consume();

        // Partial frame carrying the extreme bin, resync at bin 100, then a ce-gapped frame
        r0 = n_resync; v0 = n_rise;
        frame(2, 77, 100, 0);
        frame(0, 10, NB, 1);
        idle(5);
        chk("resync_count", n_resync - r0, 1);
        chk("resync_one_result", n_rise - v0, 1);
        chk_result("resync", 10, -10, 255, 130050);
        consume();

        // Async reset at bin 200, then unsynced samples (ignored) and one full frame
        v0 = n_rise; d0 = n_drop; r0 = n_resync;
        frame(0, 5, 200, 0);
        #2 rst_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) smp(1'b1, 1'b0, 7, 7);
        frame(1, 0, NB, 0);
        idle(5);
        chk("reset_one_result", n_rise - v0, 1);
        chk("reset_no_pulses", (n_drop - d0) + (n_resync - r0), 0);
        chk_result("post_reset", 0, 0, 0, 0);
        consume();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
